parity_check_arbiter: RTL and testbench
=======================================

// Module: parity_check_arbiter
// PURPOSE
//  - Shares one I2C data-valid (parity) checker between NUM_REQ requesters.
//  - Round-robin arbitration; drives the checker's 8-bit data and parity inputs.
//  - Samples the checker's DATA_VALID over a fixed window and returns a one-hot done pulse plus pass/fail.
//  - Sits between the I2C byte receivers and the shared checker instance, all in the FAST_CLOCK domain.
// PARAMETERS
//  NUM_REQ        4  number of requesters, 2..8
//  RESULT_WINDOW  2  cycles CHK_DATA_VALID is sampled per check, >=2 (checker output toggles when matched)
// PORTS
//  FAST_CLOCK      in   1          sole clock, posedge
//  RESET_N         in   1          synchronous active-low reset
//  REQ_VALID       in   NUM_REQ    per-requester request; held until its RSP_DONE bit
//  REQ_DATA        in   8*NUM_REQ  byte i at [8*i+7:8*i]; stable while REQ_VALID[i]
//  REQ_PARITY      in   NUM_REQ    parity bit per requester
//  REQ_GRANT       out  NUM_REQ    one-hot, high from ISSUE through RESPOND
//  RSP_DONE        out  NUM_REQ    one-hot, 1-cycle pulse in RESPOND
//  RSP_OK          out  1          result qualifier, valid only with RSP_DONE: 1 = parity matched
//  CHK_DATA        out  8          to shared checker DATA_INPUT_CHECKER (registered)
//  CHK_PARITY      out  1          to shared checker PARITY_CHECK_BIT (registered)
//  CHK_DATA_VALID  in   1          from shared checker DATA_VALID
//  BUSY            out  1          high in any state but IDLE
// BEHAVIOUR
//  - Reset (RESET_N=0 at posedge): state IDLE; all outputs 0; PTR=0; hit flag 0. Overrides any state mid-transaction; the in-flight request gets no RSP_DONE.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE. One transaction in flight.
//  - IDLE: REQ_VALID sampled only here. Winner = first set bit scanning PTR, PTR+1, ..., wrapping mod NUM_REQ.
//    - If none set, stay in IDLE.
//    - Otherwise latch WIN and go to ISSUE.
//  - ISSUE (1 cycle):
//    - Register CHK_DATA <= REQ_DATA[WIN] and CHK_PARITY <= REQ_PARITY[WIN].
//    - REQ_GRANT[WIN] <= 1. Clear hit flag and window counter.
//  - WAIT (RESULT_WINDOW+1 cycles):
//    - First WAIT cycle: CHK_DATA_VALID ignored, since it may reflect the previous byte (checker has 1-cycle registered latency).
//    - Following RESULT_WINDOW cycles: hit |= CHK_DATA_VALID.
//    - Go to RESPOND after the last cycle.
//  - RESPOND (1 cycle):
//    - RSP_DONE[WIN]=1; RSP_OK=hit.
//    - PTR <= (WIN+1) mod NUM_REQ. REQ_GRANT cleared on exit.
//  - Checker inputs (CHK_DATA, CHK_PARITY) hold their last value in IDLE; they are not zeroed.
//  - Requester handshake: drop REQ_VALID[i] in the cycle after RSP_DONE[i].
//    - If REQ_VALID[i] is still high when the FSM is back in IDLE, it is a new request with the current data.
//  - Latency: request seen in IDLE at cycle T -> RSP_DONE at T+3+RESULT_WINDOW (default T+5). Back-to-back throughput = 1 check per RESULT_WINDOW+4 cycles.
//  - Simultaneous requests: served strictly round-robin. No requester waits more than NUM_REQ-1 transactions.
//  - REQ_VALID dropped mid-transaction: the transaction completes using the latched data; RSP_DONE is still pulsed.
//  - REQ_VALID rising outside IDLE: not seen until the next IDLE.
//  - Indexing: PTR and WIN are $clog2(NUM_REQ) bits; wrap is explicit (no reliance on power-of-2 NUM_REQ).
// CONFIGURATION
//  - Macro PARITY_ARB_ERR_COUNT_EN.
//  - Defined: adds output ERR_COUNT [7:0] and input ERR_CLR (1 bit).
//    - ERR_COUNT increments in RESPOND when RSP_OK=0 and saturates at 8'hFF.
//    - ERR_CLR=1 zeroes it; clear wins over a same-cycle increment.
//    - Reset value 0.
//  - Undefined: ports ERR_COUNT and ERR_CLR are absent, no counter logic; all other behaviour identical.
// TESTING
//  - Reset mid-WAIT (RESET_N=0 for 1 cycle) -> next cycle BUSY=0, REQ_GRANT=0, RSP_DONE=0, CHK_DATA=0; PTR=0 on next grant.
//  - Single request, NUM_REQ=4: REQ_VALID=4'b0010, REQ_DATA[15:8]=8'hA5, REQ_PARITY[1]=0, checker model matches -> CHK_DATA=8'hA5 in first WAIT cycle; RSP_DONE=4'b0010 with RSP_OK=1 five cycles after request.
//  - Parity mismatch: data 8'h01, parity 0 -> RSP_OK=0. With PARITY_ARB_ERR_COUNT_EN, ERR_COUNT goes 0 -> 1.
//  - All four requesting from reset (REQ_VALID=4'hF, each held until done) -> RSP_DONE order 0001, 0010, 0100, 1000, then 0001 again if requester 0 re-requests.
//  - Stale pulse: previous byte matched, new byte mismatches -> CHK_DATA_VALID high in first WAIT cycle is ignored; RSP_OK=0.
//  - Saturation: 256 mismatches -> ERR_COUNT=8'hFF and stays there; ERR_CLR asserted in the same cycle as a mismatch -> ERR_COUNT=0.

Source files
------------

// File: rtl/parity_check_arbiter_if.sv
// Bundle of request/response and shared-checker signals for parity_check_arbiter.
// The requester/checker side uses the master modport; the arbiter uses slave.
interface parity_check_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   REQ_VALID;
    logic [8*NUM_REQ-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]   REQ_PARITY;
    logic [NUM_REQ-1:0]   REQ_GRANT;
    logic [NUM_REQ-1:0]   RSP_DONE;
    logic                 RSP_OK;
    logic [7:0]           CHK_DATA;
    logic                 CHK_PARITY;
    logic                 CHK_DATA_VALID;
    logic                 BUSY;

    modport master (
        output REQ_VALID, REQ_DATA, REQ_PARITY, CHK_DATA_VALID,
        input  REQ_GRANT, RSP_DONE, RSP_OK, CHK_DATA, CHK_PARITY, BUSY
    );

    modport slave (
        input  REQ_VALID, REQ_DATA, REQ_PARITY, CHK_DATA_VALID,
        output REQ_GRANT, RSP_DONE, RSP_OK, CHK_DATA, CHK_PARITY, BUSY
    );
endinterface

// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter sharing one parity checker among NUM_REQ requesters.
// Optional error counter (ERR_COUNT/ERR_CLR) enabled by PARITY_ARB_ERR_COUNT_EN.
module parity_check_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned RESULT_WINDOW = 2
) (
    input logic                   FAST_CLOCK,
    input logic                   RESET_N,
    parity_check_arbiter_if.slave bus
`ifdef PARITY_ARB_ERR_COUNT_EN
    ,
    output logic [7:0]            ERR_COUNT,
    input  logic                  ERR_CLR
`endif
);
    localparam int unsigned   PW       = $clog2(NUM_REQ);
    localparam int unsigned   CW       = $clog2(RESULT_WINDOW + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RESULT_WINDOW);
    localparam logic [PW-1:0] IDX_LAST = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_q, win_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit_q, hit_d;
    logic [7:0]    chk_data_q, chk_data_d;
    logic          chk_parity_q, chk_parity_d;

    logic               found;
    logic [PW-1:0]      pick;
    int unsigned        sum;
    logic [NUM_REQ-1:0] win_onehot;
    logic [7:0]         sel_data;
    logic               sel_parity;

    // Scan PTR, PTR+1, ... with explicit wrap so non-power-of-2 NUM_REQ works.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        sum   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = 32'(ptr_q) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            if (!found && bus.REQ_VALID[PW'(sum)]) begin
                found = 1'b1;
                pick  = PW'(sum);
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        sel_data   = '0;
        sel_parity = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_q == PW'(i)) begin
                win_onehot[i] = 1'b1;
                sel_data      = bus.REQ_DATA[8*i +: 8];
                sel_parity    = bus.REQ_PARITY[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        win_d        = win_q;
        cnt_d        = cnt_q;
        hit_d        = hit_q;
        chk_data_d   = chk_data_q;
        chk_parity_d = chk_parity_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d   = pick;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                chk_data_d   = sel_data;
                chk_parity_d = sel_parity;
                hit_d        = 1'b0;
                cnt_d        = '0;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                // cnt_q==0 sees the checker's response to the previous byte.
                if (cnt_q != '0) hit_d = hit_q | bus.CHK_DATA_VALID;
                if (cnt_q == CNT_LAST) state_d = S_RESPOND;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            S_RESPOND: begin
                ptr_d   = (win_q == IDX_LAST) ? '0 : win_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge FAST_CLOCK) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            win_q        <= '0;
            cnt_q        <= '0;
            hit_q        <= 1'b0;
            chk_data_q   <= '0;
            chk_parity_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            hit_q        <= hit_d;
            chk_data_q   <= chk_data_d;
            chk_parity_q <= chk_parity_d;
        end
    end

    assign bus.REQ_GRANT  = (state_q != S_IDLE) ? win_onehot : '0;
    assign bus.RSP_DONE   = (state_q == S_RESPOND) ? win_onehot : '0;
    assign bus.RSP_OK     = (state_q == S_RESPOND) && hit_q;
    assign bus.BUSY       = (state_q != S_IDLE);
    assign bus.CHK_DATA   = chk_data_q;
    assign bus.CHK_PARITY = chk_parity_q;

`ifdef PARITY_ARB_ERR_COUNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (ERR_CLR)
            err_count_d = '0;
        else if (state_q == S_RESPOND && !hit_q && err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge FAST_CLOCK) begin
        if (!RESET_N) err_count_q <= '0;
        else          err_count_q <= err_count_d;
    end

    assign ERR_COUNT = err_count_q;
`endif
endmodule

// File: tb/tb_parity_check_arbiter.sv
// Directed self-checking bench for parity_check_arbiter (NUM_REQ=4, RESULT_WINDOW=2).
// Error-counter checks are compiled in when PARITY_ARB_ERR_COUNT_EN is defined.
module tb_parity_check_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    logic dv_model = 1'b0;
    logic ovr_en   = 1'b0;
    logic ovr_val  = 1'b0;

    parity_check_arbiter_if #(.NUM_REQ(4)) bus ();

`ifdef PARITY_ARB_ERR_COUNT_EN
    logic [7:0] err_count;
    logic       err_clr = 1'b0;
`endif

    parity_check_arbiter #(
        .NUM_REQ      (4),
        .RESULT_WINDOW(2)
    ) dut (
        .FAST_CLOCK(clk),
        .RESET_N   (rst_n),
        .bus       (bus.slave)
`ifdef PARITY_ARB_ERR_COUNT_EN
        ,
        .ERR_COUNT (err_count),
        .ERR_CLR   (err_clr)
`endif
    );

    always #5 clk = ~clk;

    // Shared checker: registered, output toggles while the presented byte matches even parity.
    always @(posedge clk)
        dv_model <= ((^bus.CHK_DATA) == bus.CHK_PARITY) ? ~dv_model : 1'b0;

    assign bus.CHK_DATA_VALID = ovr_en ? ovr_val : dv_model;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered in an IDLE cycle with the request visible; returns in the following IDLE cycle.
    task automatic txn(input logic [3:0] exp_oh, input logic [7:0] exp_data, input logic exp_par,
                       input logic exp_ok, input logic stale, input logic clr);
        tick();
        chk("grant_issue", bus.REQ_GRANT, exp_oh);
        chk("busy_issue", bus.BUSY, 1'b1);
        if (stale) begin
            ovr_en  = 1'b1;
            ovr_val = 1'b1;
        end
        tick();
        chk("chk_data", bus.CHK_DATA, exp_data);
        chk("chk_parity", bus.CHK_PARITY, exp_par);
        chk("done_wait", bus.RSP_DONE, 4'b0000);
        tick();
        ovr_val = 1'b0;
        tick();
        tick();
        chk("done_respond", bus.RSP_DONE, exp_oh);
        chk("ok_respond", bus.RSP_OK, exp_ok);
        chk("grant_respond", bus.REQ_GRANT, exp_oh);
`ifdef PARITY_ARB_ERR_COUNT_EN
        if (clr) err_clr = 1'b1;
`else
        if (clr) $display("note: ERR_CLR unavailable in this build");
`endif
        tick();
        ovr_en = 1'b0;
`ifdef PARITY_ARB_ERR_COUNT_EN
        err_clr = 1'b0;
`endif
        chk("busy_idle", bus.BUSY, 1'b0);
        chk("grant_idle", bus.REQ_GRANT, 4'b0000);
        chk("done_idle", bus.RSP_DONE, 4'b0000);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.REQ_VALID  = '0;
        bus.REQ_DATA   = '0;
        bus.REQ_PARITY = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_busy", bus.BUSY, 1'b0);
        chk("rst_grant", bus.REQ_GRANT, 4'b0000);
        chk("rst_done", bus.RSP_DONE, 4'b0000);
        chk("rst_ok", bus.RSP_OK, 1'b0);
        chk("rst_chk_data", bus.CHK_DATA, 8'h00);
        chk("rst_chk_parity", bus.CHK_PARITY, 1'b0);
`ifdef PARITY_ARB_ERR_COUNT_EN
        chk("rst_err_count", err_count, 8'h00);
`endif

        // Single matching request from requester 1
        bus.REQ_VALID       = 4'b0010;
        bus.REQ_DATA[15:8]  = 8'hA5;
        bus.REQ_PARITY[1]   = 1'b0;
        txn(4'b0010, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.REQ_VALID = 4'b0000;
        tick();
        chk("idle_no_req", bus.BUSY, 1'b0);

        // Parity mismatch from requester 2
        bus.REQ_VALID       = 4'b0100;
        bus.REQ_DATA[23:16] = 8'h01;
        bus.REQ_PARITY[2]   = 1'b0;
        txn(4'b0100, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.REQ_VALID = 4'b0000;
`ifdef PARITY_ARB_ERR_COUNT_EN
        chk("err_after_mismatch", err_count, 8'h01);
`endif

        // Matching byte, then a mismatching byte with a stale checker pulse
        bus.REQ_VALID       = 4'b1000;
        bus.REQ_DATA[31:24] = 8'h03;
        bus.REQ_PARITY[3]   = 1'b0;
        txn(4'b1000, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.REQ_VALID       = 4'b0001;
        bus.REQ_DATA[7:0]   = 8'h07;
        bus.REQ_PARITY[0]   = 1'b0;
        txn(4'b0001, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.REQ_VALID = 4'b0000;
`ifdef PARITY_ARB_ERR_COUNT_EN
        chk("err_after_stale", err_count, 8'h02);
`endif

        // Reset during WAIT, then PTR must restart at 0
        bus.REQ_VALID       = 4'b0100;
        bus.REQ_DATA[23:16] = 8'h3C;
        tick();
        chk("grant_before_rst", bus.REQ_GRANT, 4'b0100);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", bus.BUSY, 1'b0);
        chk("midrst_grant", bus.REQ_GRANT, 4'b0000);
        chk("midrst_done", bus.RSP_DONE, 4'b0000);
        chk("midrst_chk_data", bus.CHK_DATA, 8'h00);
`ifdef PARITY_ARB_ERR_COUNT_EN
        chk("midrst_err_count", err_count, 8'h00);
`endif
        bus.REQ_VALID       = 4'b1001;
        bus.REQ_DATA[7:0]   = 8'hA5;
        bus.REQ_PARITY[0]   = 1'b0;
        bus.REQ_DATA[31:24] = 8'h80;
        bus.REQ_PARITY[3]   = 1'b1;
        txn(4'b0001, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.REQ_VALID = 4'b1000;
        txn(4'b1000, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.REQ_VALID = 4'b0000;

        // All four requesting from reset: strict round-robin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.REQ_DATA   = {8'h80, 8'hFF, 8'h01, 8'hA5};
        bus.REQ_PARITY = 4'b1110;
        bus.REQ_VALID  = 4'b1111;
        txn(4'b0001, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.REQ_VALID[0] = 1'b0;
        txn(4'b0010, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.REQ_VALID[1] = 1'b0;
        txn(4'b0100, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.REQ_VALID[2] = 1'b0;
        txn(4'b1000, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.REQ_VALID = 4'b0001;
        txn(4'b0001, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.REQ_VALID = 4'b0000;

`ifdef PARITY_ARB_ERR_COUNT_EN
        chk("err_after_rr", err_count, 8'h01);
        // Saturation: 254 more mismatches reach FF, further ones hold it
        bus.REQ_DATA[7:0] = 8'h01;
        bus.REQ_PARITY[0] = 1'b0;
        bus.REQ_VALID     = 4'b0001;
        for (int i = 0; i < 254; i++)
            txn(4'b0001, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("err_reach_ff", err_count, 8'hFF);
        for (int i = 0; i < 6; i++)
            txn(4'b0001, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("err_hold_ff", err_count, 8'hFF);
        txn(4'b0001, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("err_clr_wins", err_count, 8'h00);
        bus.REQ_VALID = 4'b0000;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
